// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_v4 stream FIFO.
package fifo_pkg;

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_v4_ptr.sv
// Wrapping pointer counter for FIFO storage addressing; supports non-power-of-two depths.
module fifo_v4_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_n;

  always_comb begin
    ptr_n = ptr_o;
    if (clr_i) begin
      ptr_n = '0;
    end else if (inc_i) begin
      ptr_n = (ptr_o == PTR_W'(DEPTH - 1)) ? '0 : ptr_o + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else begin
      ptr_o <= ptr_n;
    end
  end

endmodule

// File: rtl/fifo_v4.sv
// Valid/ready stream FIFO with occupancy count, programmable almost flags,
// high-watermark tracking, optional fall-through and synchronous flush.
module fifo_v4
  import fifo_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned CNT_W       = fifo_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             testmode_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  dtype             data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output dtype             data_o,
  input  logic [CNT_W-1:0] af_thresh_i,
  input  logic [CNT_W-1:0] ae_thresh_i,
  output logic [CNT_W-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  input  logic             wm_clr_i,
  output logic [CNT_W-1:0] watermark_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_depth_check
    $error("fifo_v4: DEPTH must be >= 2");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] wm_q;
  logic [CNT_W-1:0] wm_n;
  fifo_status_t     status_q;
  fifo_status_t     status_n;
  dtype             mem_q [DEPTH];

  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic unused_testmode;

  assign unused_testmode = testmode_i;

  // Fall-through forwards the input only while storage holds nothing.
  assign bypass  = FALL_THROUGH && status_q.empty && valid_i;
  assign ready_o = ~status_q.full;
  assign valid_o = ~status_q.empty | bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr];

  assign push  = valid_i & ready_o;
  assign pop   = valid_o & ready_i;
  assign wr_en = push & ~(bypass & ready_i) & ~flush_i;
  assign rd_en = pop & ~bypass & ~flush_i;

  fifo_v4_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  fifo_v4_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (rd_en),
    .ptr_o (rd_ptr)
  );

  // Next count, flags and watermark are all derived from the same count_n.
  always_comb begin
    count_n  = count_q;
    status_n = status_q;
    wm_n     = wm_q;
    if (flush_i) begin
      count_n = '0;
    end else begin
      count_n = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
    status_n.full         = (count_n == CNT_W'(DEPTH));
    status_n.empty        = (count_n == '0);
    status_n.almost_full  = (count_n >= af_thresh_i);
    status_n.almost_empty = (count_n <= ae_thresh_i);
    if (wm_clr_i) begin
      wm_n = count_n;
    end else if (count_n > wm_q) begin
      wm_n = count_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wm_q     <= '0;
      status_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      count_q  <= count_n;
      wm_q     <= wm_n;
      status_q <= status_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  assign usage_o        = count_q;
  assign full_o         = status_q.full;
  assign empty_o        = status_q.empty;
  assign almost_full_o  = status_q.almost_full;
  assign almost_empty_o = status_q.almost_empty;
  assign watermark_o    = wm_q;

  a_af_thresh_range: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(af_thresh_i) <= DEPTH + 1);
  a_usage_range: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(count_q) <= DEPTH);

endmodule
